pipe_stage_reg: RTL

//   Generic pipeline-stage register; successor to the fixed-field decode/execute latch.

---
 rtl/pipe_pkg.sv | 46 ++++
 rtl/pipe_skid_buf.sv | 64 ++++++
 rtl/pipe_stage_reg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the pipeline-stage register family.
//   - Default CTRL_W / DATA_W per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Bit offsets of the WB / M / EX sub-fields inside the control bundle.
//   - Bubble value (all zero) loaded into the control bundle on flush/drain.
//   - State type of the one-entry skid buffer (used when PIPE_STAGE_SKID_EN
//     is defined).
// -----------------------------------------------------------------------------
package pipe_pkg;

   // Generic defaults for pipe_stage_reg
   localparam int PIPE_CTRL_W_DEF = 8;
   localparam int PIPE_DATA_W_DEF = 128;
   localparam int PIPE_CNT_W_DEF  = 16;

   // Per-boundary bundle widths
   localparam int IFID_CTRL_W  = 8;
   localparam int IFID_DATA_W  = 64;   // pc + instruction word
   localparam int IDEX_CTRL_W  = 8;
   localparam int IDEX_DATA_W  = 128;  // operands, immediate, register indices
   localparam int EXMEM_CTRL_W = 8;
   localparam int EXMEM_DATA_W = 96;   // alu result, store data, rd
   localparam int MEMWB_CTRL_W = 8;
   localparam int MEMWB_DATA_W = 72;   // writeback value, rd

   // Control bundle layout: {WB[1:0], M[2:0], EX[2:0]}
   localparam int CTRL_EX_LSB = 0;
   localparam int CTRL_EX_W   = 3;
   localparam int CTRL_M_LSB  = CTRL_EX_LSB + CTRL_EX_W;
   localparam int CTRL_M_W    = 3;
   localparam int CTRL_WB_LSB = CTRL_M_LSB + CTRL_M_W;
   localparam int CTRL_WB_W   = 2;

   // A bubble is an all-zero control bundle: no writeback, no memory access.
   // Wide enough for any control bundle; users slice the low CTRL_W bits.
   localparam int PIPE_MAX_CTRL_W = 64;
   localparam logic [PIPE_MAX_CTRL_W-1:0] BUBBLE_CTRL = '0;

   // One-entry skid buffer occupancy
   typedef enum logic {
      SKID_EMPTY = 1'b0,
      SKID_FULL  = 1'b1
   } skid_state_e;

endpackage : pipe_pkg

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//   One-entry holding register used by pipe_stage_reg to park a beat that was
//   accepted while the output register could not take it.
//   Ports:
//     clk_i    in   clock, rising edge
//     rst_i    in   asynchronous reset, active-high (entry empty, data zero)
//     wr_en    in   load wr_data; entry becomes full (wins over clr_en)
//     clr_en   in   entry drained or flushed; becomes empty
//     wr_data  in   W-bit beat {ctrl, data}
//     full     out  entry holds a beat
//     rd_data  out  stored beat
//     state    out  occupancy state (debug / checker visibility)
// -----------------------------------------------------------------------------
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int W = 136
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_en,
   input  logic         clr_en,
   input  logic [W-1:0] wr_data,
   output logic         full,
   output logic [W-1:0] rd_data,
   output skid_state_e  state
);

   skid_state_e  state_q;
   skid_state_e  state_d;
   logic [W-1:0] data_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= SKID_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A write in the same cycle as a drain re-fills the entry with the new beat.
   always_comb begin
      state_d = state_q;
      if (wr_en) begin
         state_d = SKID_FULL;
      end else if (clr_en) begin
         state_d = SKID_EMPTY;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
      end else if (wr_en) begin
         data_q <= wr_data;
      end
   end

   assign full    = (state_q == SKID_FULL);
   assign rd_data = data_q;
   assign state   = state_q;

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic pipeline-stage register between two stages. Carries a control
//   bundle (zeroed to a bubble on flush/drain) and a datapath bundle with one
//   cycle of latency, a stall/flush interface for the hazard unit and a
//   saturating bubble counter.
//
//   Handshake: a beat moves on an edge where valid and ready are both high
//   (accept = in_valid_i & in_ready_o, release = out_valid_o & out_ready_i).
//   A producer holding valid must keep its payload stable until it is taken;
//   ready may be high without valid and never depends on in_valid_i.
//
//   Ports:
//     clk_i, rst_i            clock (rising) / async active-high reset
//     in_valid_i, in_ready_o  upstream handshake
//     in_ctrl_i, in_data_i    upstream control / datapath bundles
//     stall_i                 freeze the stage (flush_i wins)
//     flush_i                 kill contents, insert bubble
//     out_valid_o, out_ready_i downstream handshake
//     out_ctrl_o, out_data_o  registered bundles
//     bubble_cnt_o            cycles downstream was ready but stage empty
//
//   Build option PIPE_STAGE_SKID_EN: adds a one-entry skid buffer so that
//   in_ready_o comes straight from a flop (no path from out_ready_i).
//   Without it, in_ready_o is combinational.
// -----------------------------------------------------------------------------
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = PIPE_CTRL_W_DEF,
   parameter int DATA_W = PIPE_DATA_W_DEF,
   parameter int CNT_W  = PIPE_CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [CTRL_W-1:0] in_ctrl_i,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [CTRL_W-1:0] out_ctrl_o,
   output logic [DATA_W-1:0] out_data_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   localparam logic [CTRL_W-1:0] BUBBLE = BUBBLE_CTRL[CTRL_W-1:0];

   logic              out_valid_q;
   logic              out_valid_d;
   logic [CTRL_W-1:0] out_ctrl_q;
   logic [CTRL_W-1:0] out_ctrl_d;
   logic [DATA_W-1:0] out_data_q;
   logic [DATA_W-1:0] out_data_d;
   logic [CNT_W-1:0]  bubble_cnt_q;

   logic accept;
   logic release_beat;
   logic out_free;

   assign accept       = in_valid_i & in_ready_o;
   assign release_beat = out_valid_q & out_ready_i;
   // Output register may take a new beat this cycle (empty or being drained)
   assign out_free     = !out_valid_q || out_ready_i;

`ifdef PIPE_STAGE_SKID_EN
   logic                     ready_q;
   logic                     skid_wr;
   logic                     skid_clr;
   logic                     skid_full;
   logic                     skid_full_next;
   logic [CTRL_W+DATA_W-1:0] skid_rd;
   skid_state_e              skid_state;

   pipe_skid_buf #(
      .W (CTRL_W + DATA_W)
   ) u_skid (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .wr_en   (skid_wr),
      .clr_en  (skid_clr),
      .wr_data ({in_ctrl_i, in_data_i}),
      .full    (skid_full),
      .rd_data (skid_rd),
      .state   (skid_state)
   );

   assign in_ready_o = ready_q;

   // ready_q was computed last cycle, so a beat can still arrive during a
   // flush or stall cycle. It is never dropped: it parks in the (empty) skid
   // entry and moves to the output once the stage runs again. ready_q high
   // guarantees the skid entry is empty, so parking never overwrites a beat.
   always_comb begin
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      out_data_d  = out_data_q;
      skid_wr     = 1'b0;
      skid_clr    = 1'b0;
      if (flush_i) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = BUBBLE;
         skid_clr    = 1'b1;
         skid_wr     = accept;
      end else if (stall_i) begin
         skid_wr     = accept;
      end else if (out_free) begin
         if (skid_full) begin
            // Oldest beat first: skid -> output, new beat (if any) -> skid
            out_valid_d = 1'b1;
            {out_ctrl_d, out_data_d} = skid_rd;
            skid_clr    = 1'b1;
            skid_wr     = accept;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_ctrl_d  = in_ctrl_i;
            out_data_d  = in_data_i;
         end else if (release_beat) begin
            out_valid_d = 1'b0;
            out_ctrl_d  = BUBBLE;
         end
      end else begin
         skid_wr     = accept;
      end
   end

   assign skid_full_next = skid_wr || (skid_full && !skid_clr);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ready_q <= 1'b1;
      end else begin
         ready_q <= !skid_full_next && !stall_i;
      end
   end
`else
   assign in_ready_o = !stall_i && !flush_i && out_free;

   always_comb begin
      out_valid_d = out_valid_q;
      out_ctrl_d  = out_ctrl_q;
      out_data_d  = out_data_q;
      if (flush_i) begin
         // Datapath bundle is left as-is; only valid/control matter for a bubble
         out_valid_d = 1'b0;
         out_ctrl_d  = BUBBLE;
      end else if (stall_i) begin
         out_valid_d = out_valid_q;
      end else if (accept) begin
         out_valid_d = 1'b1;
         out_ctrl_d  = in_ctrl_i;
         out_data_d  = in_data_i;
      end else if (release_beat) begin
         out_valid_d = 1'b0;
         out_ctrl_d  = BUBBLE;
      end
   end
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_ctrl_q  <= '0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_ctrl_q  <= out_ctrl_d;
         out_data_q  <= out_data_d;
      end
   end

   // Counts lost downstream slots; sticks at all-ones instead of wrapping
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bubble_cnt_q <= '0;
      end else if (!out_valid_q && out_ready_i && !stall_i && (bubble_cnt_q != '1)) begin
         bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_ctrl_o   = out_ctrl_q;
   assign out_data_o   = out_data_q;
   assign bubble_cnt_o = bubble_cnt_q;

endmodule : pipe_stage_reg
